// File: rtl/sdram_ports_pkg.sv
// ----------------------------------------------------------------------------
// sdram_ports_pkg : types and constants shared by the SDRAM port block
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package sdram_ports_pkg;

  localparam int          FRAME_PIXELS        = 307200;
  localparam logic [15:0] VGA_NULL_DATA_COLOR = 16'd500;

  typedef logic [18:0] pix_idx_t;
  typedef logic [24:0] sdram_addr_t;

endpackage

`default_nettype wire

// File: rtl/address_tracker_if.sv
// ----------------------------------------------------------------------------
// address_tracker_if : SDRAM read-return / VGA FIFO write-side bundle
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface address_tracker_if;
  import sdram_ports_pkg::sdram_addr_t;

  logic        readValid;
  sdram_addr_t raddr;
  sdram_addr_t readOffset;
  logic [8:0]  PortVout_usedw;
  logic        PortVout_wrreq;
  logic        PortVout_nullData;

  modport master (
    output readValid, raddr, readOffset, PortVout_usedw,
    input  PortVout_wrreq, PortVout_nullData
  );

  modport slave (
    input  readValid, raddr, readOffset, PortVout_usedw,
    output PortVout_wrreq, PortVout_nullData
  );

endinterface

`default_nettype wire

// File: rtl/address_tracker.sv
// ----------------------------------------------------------------------------
// address_tracker : VGA FIFO write sequencer; keeps in-order SDRAM returns and
// inserts null pixels to avoid underrun. Optional macro ADDRESS_TRACKER_STATS_EN
// adds a saturating null-fill counter output (nullCount).
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module address_tracker
  import sdram_ports_pkg::pix_idx_t;
  import sdram_ports_pkg::sdram_addr_t;
#(
  parameter int         FRAME_PIXELS = sdram_ports_pkg::FRAME_PIXELS,
  parameter logic [8:0] LOW_WATER    = 9'd16,
  parameter logic [8:0] HIGH_WATER   = 9'd504
) (
  input  logic              clk,
  input  logic              rst,
`ifdef ADDRESS_TRACKER_STATS_EN
  output logic [15:0]       nullCount,
`endif
  address_tracker_if.slave  bus
);

  localparam pix_idx_t LAST_PIX = pix_idx_t'(FRAME_PIXELS - 1);

  function automatic pix_idx_t next_pix(input pix_idx_t p);
    return (p == LAST_PIX) ? '0 : p + pix_idx_t'(1);
  endfunction

  pix_idx_t    r_exp_pix;
  sdram_addr_t w_exp_addr;
  logic        w_below_high;
  logic        w_match;
  logic        w_starving;
  logic        w_wrreq;
  logic        w_null_data;

  // 25-bit add wraps naturally, matching the SDRAM word address space
  assign w_exp_addr   = bus.readOffset + {6'd0, r_exp_pix};
  assign w_below_high = bus.PortVout_usedw < HIGH_WATER;
  assign w_match      = bus.readValid && (bus.raddr == w_exp_addr) && w_below_high;
  assign w_starving   = (bus.PortVout_usedw < LOW_WATER) && w_below_high;

  always_comb begin
    w_wrreq     = 1'b0;
    w_null_data = 1'b0;
    if (!rst) begin
      if (w_match) begin
        w_wrreq = 1'b1;
      end else if (w_starving) begin
        w_wrreq     = 1'b1;
        w_null_data = 1'b1;
      end
    end
  end

  assign bus.PortVout_wrreq    = w_wrreq;
  assign bus.PortVout_nullData = w_null_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_exp_pix <= '0;
    end else if (w_wrreq) begin
      r_exp_pix <= next_pix(r_exp_pix);
    end
  end

`ifdef ADDRESS_TRACKER_STATS_EN
  logic [15:0] r_null_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_null_count <= '0;
    end else if (w_wrreq && w_null_data && (r_null_count != 16'hFFFF)) begin
      r_null_count <= r_null_count + 16'd1;
    end
  end

  assign nullCount = r_null_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_address_tracker.sv
// ----------------------------------------------------------------------------
// tb_address_tracker : directed vectors with a queue-based scoreboard
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_address_tracker;

  localparam int TB_FRAME = 12;

  typedef struct {
    logic  rst;
    logic  wr;
    logic  nul;
    string name;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp  = 0;
  int   n_fail = 0;
  exp_t q[$];

  address_tracker_if vif ();

`ifdef ADDRESS_TRACKER_STATS_EN
  logic [15:0] nullCount;
  logic [15:0] m_cnt = 16'd0;
`endif

  address_tracker #(
    .FRAME_PIXELS (TB_FRAME),
    .LOW_WATER    (9'd16),
    .HIGH_WATER   (9'd504)
  ) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef ADDRESS_TRACKER_STATS_EN
    .nullCount (nullCount),
`endif
    .bus       (vif)
  );

  always #5 clk = ~clk;

  task automatic vec(input logic r, input logic rv, input logic [24:0] a,
                     input logic [24:0] off, input logic [8:0] uw,
                     input logic ew, input logic en, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    rst              = r;
    vif.readValid    = rv;
    vif.raddr        = a;
    vif.readOffset   = off;
    vif.PortVout_usedw = uw;
    e.rst  = r;
    e.wr   = ew;
    e.nul  = en;
    e.name = nm;
    q.push_back(e);
  endtask

  // Monitor: outputs are combinational, so every driven cycle is checked
  always @(negedge clk) begin : monitor
    exp_t e;
    if (q.size() != 0) begin
      e = q.pop_front();
      n_cmp++;
      if ({vif.PortVout_wrreq, vif.PortVout_nullData} !== {e.wr, e.nul}) begin
        n_fail++;
        $display("FAIL %s: wrreq/nullData got %b/%b expected %b/%b", e.name,
                 vif.PortVout_wrreq, vif.PortVout_nullData, e.wr, e.nul);
      end
`ifdef ADDRESS_TRACKER_STATS_EN
      if (!e.rst) begin
        n_cmp++;
        if (nullCount !== m_cnt) begin
          n_fail++;
          $display("FAIL %s nullCount: got %0d expected %0d", e.name, nullCount, m_cnt);
        end
      end
      if (e.rst) m_cnt = 16'd0;
      else if (e.wr && e.nul && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
`endif
    end
  end

  initial begin
    vif.readValid      = 1'b0;
    vif.raddr          = '0;
    vif.readOffset     = '0;
    vif.PortVout_usedw = 9'd100;

    //   rst rv raddr         offset        usedw  wr null  name
    vec(1, 1, 25'h0,       25'h0,       9'd100, 0, 0, "reset_hold");
    vec(1, 0, 25'h0,       25'h0,       9'd5,   0, 0, "reset_low_fill");
    vec(0, 1, 25'h0,       25'h0,       9'd100, 1, 0, "first_match");
    vec(1, 0, 25'h0,       25'h0,       9'd100, 0, 0, "reset2");
    vec(0, 1, 25'h1000,    25'h1000,    9'd100, 1, 0, "offset_match");
    vec(0, 1, 25'h1005,    25'h1000,    9'd100, 0, 0, "offset_mismatch");
    vec(0, 0, 25'h1005,    25'h1000,    9'd100, 0, 0, "idle");
    vec(0, 1, 25'h1001,    25'h1000,    9'd100, 1, 0, "held_pix1");
    vec(0, 0, 25'h0,       25'h1000,    9'd5,   1, 1, "null_0");
    vec(0, 0, 25'h0,       25'h1000,    9'd5,   1, 1, "null_1");
    vec(0, 0, 25'h0,       25'h1000,    9'd5,   1, 1, "null_2");
    vec(0, 1, 25'h1005,    25'h1000,    9'd100, 1, 0, "after_null");
    vec(0, 1, 25'h1006,    25'h1000,    9'd5,   1, 0, "match_beats_null");
    vec(0, 0, 25'h0,       25'h1000,    9'd16,  0, 0, "low_edge_16");
    vec(0, 0, 25'h0,       25'h1000,    9'd15,  1, 1, "low_edge_15");
    vec(0, 1, 25'h1008,    25'h1000,    9'd504, 0, 0, "full_504");
    vec(0, 1, 25'h1008,    25'h1000,    9'd511, 0, 0, "full_511");
    vec(0, 1, 25'h1008,    25'h1000,    9'd503, 1, 0, "below_full_503");
    vec(0, 1, 25'h1009,    25'h1000,    9'd100, 1, 0, "pix9");
    vec(0, 1, 25'h100A,    25'h1000,    9'd100, 1, 0, "pix10");
    vec(0, 1, 25'h100B,    25'h1000,    9'd100, 1, 0, "last_pix");
    vec(0, 1, 25'h100C,    25'h1000,    9'd100, 0, 0, "no_overrun");
    vec(0, 1, 25'h1000,    25'h1000,    9'd100, 1, 0, "wrapped_pix0");
    vec(0, 1, 25'h1,       25'h0,       9'd100, 1, 0, "offset_change");
    vec(0, 1, 25'h1,       25'h1FFFFFF, 9'd100, 1, 0, "addr_wrap25");
    vec(1, 1, 25'h2,       25'h1FFFFFF, 9'd5,   0, 0, "mid_reset");
    vec(0, 1, 25'h1FFFFFF, 25'h1FFFFFF, 9'd100, 1, 0, "post_reset_pix0");

    @(posedge clk);
    #1;
    vif.readValid      = 1'b0;
    vif.PortVout_usedw = 9'd100;
    for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
